// File: rtl/ccff_bitstream_loader_if.sv
// Word stream from the configuration controller into the chain loader.
// The master drives words and the slave (the loader) returns ready.
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] cfg_wdata;
    logic              cfg_wvalid;
    logic              cfg_wready;

    modport master (output cfg_wdata, output cfg_wvalid, input cfg_wready);
    modport slave  (input cfg_wdata, input cfg_wvalid, output cfg_wready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words LSB-first onto the CLB configuration chain.
// It gates prog_clk advance through ccff_shift_en and can optionally verify ccff_tail against the resent data.
module ccff_bitstream_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 4096,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1),
    parameter int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W
) (
    input  logic                    prog_clk,
    input  logic                    pReset,
    input  logic                    start,
    input  logic                    verify,
    ccff_bitstream_loader_if.slave  cfg,
    output logic                    ccff_head,
    output logic                    ccff_shift_en,
    input  logic                    ccff_tail,
    output logic                    busy,
    output logic                    done,
    output logic                    mismatch,
    output logic [15:0]             mismatch_cnt
);
    localparam int WA_W = $clog2(NWORDS + 1);
    localparam int AB_W = $clog2(WORD_W + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WA_W-1:0]   r_words_acc;
    logic              r_verify;
    logic [WORD_W-1:0] r_act;
    logic              r_act_valid;
    logic [AB_W-1:0]   r_act_bits;
    logic [WORD_W-1:0] r_pend;
    logic              r_pend_valid;
    logic              r_head_hold;
    logic              r_mismatch;
    logic [15:0]       r_mismatch_cnt;

    logic w_wready;
    logic w_accept;
    logic w_shift;
    logic w_act_free;
    logic w_last_bit;

    assign w_wready   = (r_state == S_SHIFT) && !r_pend_valid && (r_words_acc < WA_W'(NWORDS));
    assign w_accept   = cfg.cfg_wvalid && w_wready;
    assign w_shift    = (r_state == S_SHIFT) && r_act_valid;
    // The active register can take a new word on the same edge its final bit leaves, so words chain without bubbles.
    assign w_act_free = !r_act_valid || (w_shift && (r_act_bits == AB_W'(1)));
    assign w_last_bit = w_shift && (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));

    assign cfg.cfg_wready = w_wready;
    assign ccff_shift_en  = w_shift;
    assign ccff_head      = r_act_valid ? r_act[0] : r_head_hold;
    assign busy           = (r_state == S_SHIFT);
    assign done           = (r_state == S_FINISH);
    assign mismatch       = r_mismatch;
    assign mismatch_cnt   = r_mismatch_cnt;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state        <= S_IDLE;
            r_bit_cnt      <= '0;
            r_words_acc    <= '0;
            r_verify       <= 1'b0;
            r_act          <= '0;
            r_act_valid    <= 1'b0;
            r_act_bits     <= '0;
            r_pend         <= '0;
            r_pend_valid   <= 1'b0;
            r_head_hold    <= 1'b0;
            r_mismatch     <= 1'b0;
            r_mismatch_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state        <= S_SHIFT;
                        r_bit_cnt      <= '0;
                        r_words_acc    <= '0;
                        r_verify       <= verify;
                        r_mismatch     <= 1'b0;
                        r_mismatch_cnt <= '0;
                        r_act_valid    <= 1'b0;
                        r_pend_valid   <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (w_accept) begin
                        r_words_acc <= r_words_acc + 1'b1;
                    end
                    if (w_shift) begin
                        r_act       <= r_act >> 1;
                        r_act_bits  <= r_act_bits - 1'b1;
                        r_bit_cnt   <= r_bit_cnt + 1'b1;
                        r_head_hold <= r_act[0];
                        if (r_verify && (ccff_tail != r_act[0])) begin
                            r_mismatch <= 1'b1;
                            if (r_mismatch_cnt != 16'hFFFF) begin
                                r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
                            end
                        end
                    end
                    if (w_act_free) begin
                        if (r_pend_valid) begin
                            r_act        <= r_pend;
                            r_act_bits   <= AB_W'(WORD_W);
                            r_act_valid  <= 1'b1;
                            r_pend_valid <= 1'b0;
                        end else if (w_accept) begin
                            r_act       <= cfg.cfg_wdata;
                            r_act_bits  <= AB_W'(WORD_W);
                            r_act_valid <= 1'b1;
                        end else begin
                            r_act_valid <= 1'b0;
                        end
                    end else if (w_accept) begin
                        r_pend       <= cfg.cfg_wdata;
                        r_pend_valid <= 1'b1;
                    end
                    // Unused upper bits of the final word are dropped here.
                    if (w_last_bit) begin
                        r_state      <= S_FINISH;
                        r_act_valid  <= 1'b0;
                        r_pend_valid <= 1'b0;
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Self-checking bench for ccff_bitstream_loader driving a 70-flop chain model.
// It applies table vectors, hand-written reset and stray-start sequences, and random sessions checked against a bit-level model.
module tb_ccff_bitstream_loader;
    localparam int WORD_W    = 32;
    localparam int CHAIN_LEN = 70;
    localparam int NWORDS    = 3;
    localparam int STALL     = 45;

    typedef struct {
        logic [95:0] words;
        int          stall;
        logic        ver;
        int          startMid;
        int          expMis;
    } vec_t;

    logic        prog_clk = 1'b0;
    logic        pReset;
    logic        start;
    logic        verify;
    logic        ccff_head;
    logic        ccff_shift_en;
    logic        ccff_tail;
    logic        busy;
    logic        done;
    logic        mismatch;
    logic [15:0] mismatch_cnt;
    logic [CHAIN_LEN-1:0] chain = '0;

    int checks = 0;
    int errors = 0;

    ccff_bitstream_loader_if #(.WORD_W(WORD_W)) bus ();

    ccff_bitstream_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .verify        (verify),
        .cfg           (bus),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .mismatch      (mismatch),
        .mismatch_cnt  (mismatch_cnt)
    );

    always #5 prog_clk = ~prog_clk;

    // The chain: head enters at bit 0 and the tail is the far end, so after a full pass the tail holds stream bit 0.
    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    end
    assign ccff_tail = chain[CHAIN_LEN-1];

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [95:0] words, input int stall, input logic ver,
                                 input int startMid, input int resetAt, input int expMis);
        int cyc, shifts, firstShift, firstAccept, lastShiftCyc, gaps, headBad;
        int doneCnt, busyBad, wIdx, stallCnt, afterDone, modelMis, accepted;
        logic lastHead, aborted, midDone;
        logic [CHAIN_LEN-1:0] expChain;

        modelMis = 0;
        for (int j = 0; j < CHAIN_LEN; j++) begin
            expChain[CHAIN_LEN-1-j] = words[j];
            if (chain[CHAIN_LEN-1-j] != words[j]) modelMis++;
        end
        if (!ver) modelMis = 0;
        if (expMis >= 0) modelMis = expMis;

        cyc = 0; shifts = 0; firstShift = -1; firstAccept = -1; lastShiftCyc = 0; gaps = 0;
        headBad = 0; doneCnt = 0; busyBad = 0; wIdx = 0; stallCnt = 0; afterDone = 0; accepted = 0;
        lastHead = 1'b0; aborted = 1'b0; midDone = 1'b0;

        @(negedge prog_clk);
        start = 1'b1;
        verify = ver;
        bus.cfg_wvalid = 1'b1;
        bus.cfg_wdata = words[31:0];
        checkOutput("wreadyIdle", bus.cfg_wready, 0);

        while (cyc < 600 && !aborted && !(doneCnt > 0 && afterDone >= 3)) begin
            @(negedge prog_clk);
            cyc++;
            start = 1'b0;
            if (ccff_shift_en) begin
                if (shifts == 0) firstShift = cyc;
                else if (lastShiftCyc != cyc - 1) gaps += cyc - lastShiftCyc - 1;
                shifts++;
                lastShiftCyc = cyc;
                lastHead = ccff_head;
            end else if (shifts > 0 && shifts < CHAIN_LEN && ccff_head !== lastHead) begin
                headBad++;
            end
            if (done) begin
                doneCnt++;
                if (busy) busyBad++;
            end
            if (doneCnt > 0) afterDone++;
            if (resetAt >= 0 && shifts == resetAt) begin
                pReset = 1'b1;
                bus.cfg_wvalid = 1'b0;
                aborted = 1'b1;
            end else begin
                if (startMid >= 0 && shifts == startMid && !midDone) begin
                    start = 1'b1;
                    verify = ~ver;
                    midDone = 1'b1;
                end
                if (wIdx == 1 && stallCnt < stall) begin
                    bus.cfg_wvalid = 1'b0;
                    stallCnt++;
                end else if (wIdx < NWORDS) begin
                    bus.cfg_wvalid = 1'b1;
                    bus.cfg_wdata = words[wIdx*32 +: 32];
                end else begin
                    bus.cfg_wvalid = 1'b0;
                end
                if (bus.cfg_wvalid && bus.cfg_wready) begin
                    if (wIdx == 0) firstAccept = cyc;
                    wIdx++;
                    accepted++;
                end
            end
        end

        if (aborted) begin
            @(negedge prog_clk);
            checkOutput("rstBusy", busy, 0);
            checkOutput("rstShiftEn", ccff_shift_en, 0);
            checkOutput("rstWready", bus.cfg_wready, 0);
            checkOutput("rstDone", done, 0);
            checkOutput("rstMisCnt", mismatch_cnt, 0);
            pReset = 1'b0;
        end else begin
            checkOutput("shiftCount", shifts, CHAIN_LEN);
            checkOutput("wordsAccepted", accepted, NWORDS);
            checkOutput("donePulses", doneCnt, 1);
            checkOutput("busyAtDone", busyBad, 0);
            checkOutput("firstShiftLatency", firstShift - firstAccept, 1);
            if (stall == 0) checkOutput("shiftGaps", gaps, 0);
            else checkOutput("stallGapAtLeast5", gaps >= 5, 1);
            checkOutput("headStableInStall", headBad, 0);
            checkOutput("chainContents", chain, expChain);
            checkOutput("mismatchFlag", mismatch, modelMis > 0);
            checkOutput("mismatchCnt", mismatch_cnt, modelMis);
            checkOutput("busyAfter", busy, 0);
        end
    endtask

    initial begin
        vec_t vecs[5];
        logic [95:0] baseWords;
        logic [95:0] rnd;

        baseWords = {32'h0000003F, 32'h0F0F0F0F, 32'hA5A5A5A5};
        vecs[0] = '{words: baseWords, stall: 0, ver: 1'b0, startMid: -1, expMis: 0};
        vecs[1] = '{words: baseWords, stall: STALL, ver: 1'b0, startMid: -1, expMis: 0};
        vecs[2] = '{words: baseWords, stall: 0, ver: 1'b1, startMid: -1, expMis: 0};
        vecs[3] = '{words: baseWords ^ 96'h8, stall: 0, ver: 1'b1, startMid: -1, expMis: 1};
        vecs[4] = '{words: baseWords, stall: 0, ver: 1'b1, startMid: 20, expMis: 1};

        pReset = 1'b1;
        start = 1'b0;
        verify = 1'b0;
        bus.cfg_wvalid = 1'b0;
        bus.cfg_wdata = '0;
        repeat (3) @(negedge prog_clk);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        checkOutput("resetShiftEn", ccff_shift_en, 0);
        checkOutput("resetWready", bus.cfg_wready, 0);
        checkOutput("resetHead", ccff_head, 0);
        checkOutput("resetMismatch", mismatch, 0);
        checkOutput("resetMisCnt", mismatch_cnt, 0);
        pReset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i].words, vecs[i].stall, vecs[i].ver, vecs[i].startMid, -1, vecs[i].expMis);
        end

        // Abort after 40 shifts, then confirm a fresh session loads and verifies cleanly.
        $display("[TB] reset mid-session");
        applyStimulus(baseWords, 0, 1'b0, -1, 40, -1);
        applyStimulus(baseWords, 0, 1'b0, -1, -1, 0);
        applyStimulus(baseWords, 0, 1'b1, -1, -1, 0);

        for (int i = 0; i < 6; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            $display("[TB] random session %0d", i);
            applyStimulus(rnd, ($urandom_range(0, 1) == 1) ? STALL : 0, 1'($urandom_range(0, 1)), -1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
